// File: rtl/vga_pkg.sv
// Shared VGA timing constants, pipeline flag bundle and test-bar colour table.
package vga_pkg;

  localparam int VGA640_H_VISIBLE  = 640;
  localparam int VGA640_H_FRONT    = 16;
  localparam int VGA640_H_SYNC     = 96;
  localparam int VGA640_H_BACK     = 48;
  localparam int VGA640_V_VISIBLE  = 480;
  localparam int VGA640_V_FRONT    = 10;
  localparam int VGA640_V_SYNC     = 2;
  localparam int VGA640_V_BACK     = 33;

  localparam int VGA1024_H_VISIBLE = 1024;
  localparam int VGA1024_H_FRONT   = 24;
  localparam int VGA1024_H_SYNC    = 136;
  localparam int VGA1024_H_BACK    = 160;
  localparam int VGA1024_V_VISIBLE = 768;
  localparam int VGA1024_V_FRONT   = 3;
  localparam int VGA1024_V_SYNC    = 6;
  localparam int VGA1024_V_BACK    = 29;

  // Per-position flags that travel down the delay line alongside the colour fetch.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } scan_flags_t;

  typedef enum logic [2:0] {
    BAR_BLACK,
    BAR_BLUE,
    BAR_GREEN,
    BAR_CYAN,
    BAR_RED,
    BAR_MAGENTA,
    BAR_YELLOW,
    BAR_WHITE
  } bar_e;

  // {r,g,b} channel enables, each channel driven all-ones or zero.
  localparam logic [2:0] BAR_RGB [8] = '{
    3'b000, 3'b001, 3'b010, 3'b011,
    3'b100, 3'b101, 3'b110, 3'b111
  };

  function automatic logic [2:0] bar_rgb(input bar_e bar);
    return BAR_RGB[int'(bar)];
  endfunction

endpackage

// File: rtl/vga_scan_gen_if.sv
// Pixel fetch request / colour return and video output bundle for vga_scan_gen.
interface vga_scan_gen_if #(
  parameter int COORD_W = 11,
  parameter int COLOR_W = 8
);
  logic                   req;
  logic [COORD_W-1:0]     req_x;
  logic [COORD_W-1:0]     req_y;
  logic                   line_start;
  logic                   frame_start;
  logic [3*COLOR_W-1:0]   color_in;
  logic                   hsync;
  logic                   vsync;
  logic                   de;
  logic [COLOR_W-1:0]     red;
  logic [COLOR_W-1:0]     green;
  logic [COLOR_W-1:0]     blue;

  modport master (
    output req, req_x, req_y, line_start, frame_start,
    output hsync, vsync, de, red, green, blue,
    input  color_in
  );

  modport slave (
    input  req, req_x, req_y, line_start, frame_start,
    input  hsync, vsync, de, red, green, blue,
    output color_in
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One scan axis: counts visible, front porch, sync, back porch and wraps.
module vga_axis_counter #(
  parameter int VISIBLE = 1024,
  parameter int FRONT   = 24,
  parameter int SYNC    = 136,
  parameter int BACK    = 160,
  parameter int W       = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         visible,
  output logic         in_sync
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;
  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END  = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_BEG = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] SYNC_END = W'(VISIBLE + FRONT + SYNC);

  assign wrap    = en && (cnt == LAST);
  assign visible = (cnt < VIS_END);
  assign in_sync = (cnt >= SYNC_BEG) && (cnt < SYNC_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// VGA scan generator: fetch requests, then sync/de/rgb aligned PRE_ACTIVE+1 cycles later.
// Optional colour-bar test pattern enabled by macro VGA_TEST_PATTERN_EN.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = VGA1024_H_VISIBLE,
  parameter int H_FRONT    = VGA1024_H_FRONT,
  parameter int H_SYNC     = VGA1024_H_SYNC,
  parameter int H_BACK     = VGA1024_H_BACK,
  parameter int V_VISIBLE  = VGA1024_V_VISIBLE,
  parameter int V_FRONT    = VGA1024_V_FRONT,
  parameter int V_SYNC     = VGA1024_V_SYNC,
  parameter int V_BACK     = VGA1024_V_BACK,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int PRE_ACTIVE = 1,
  parameter int COORD_W    = 11,
  parameter int COLOR_W    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            test_mode,
  vga_scan_gen_if.master  bus
);

  localparam logic        HS_ON = (HS_POL != 0);
  localparam logic        VS_ON = (VS_POL != 0);
  localparam int unsigned DEPTH = PRE_ACTIVE;

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap;
  logic               h_vis;
  logic               h_sync;
  logic               v_vis;
  logic               v_sync;
  logic               unused_v_wrap;
  logic               scan_vis;

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK),
    .W       (COORD_W)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (1'b1),
    .cnt     (h_cnt),
    .wrap    (h_wrap),
    .visible (h_vis),
    .in_sync (h_sync)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK),
    .W       (COORD_W)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (h_wrap),
    .cnt     (v_cnt),
    .wrap    (unused_v_wrap),
    .visible (v_vis),
    .in_sync (v_sync)
  );

  assign scan_vis = h_vis && v_vis;

  // Request stage: registered so reset forces req low while the counters sit at (0,0).
  scan_flags_t req_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      req_flags       <= '0;
      bus.req_x       <= '0;
      bus.req_y       <= '0;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else begin
      req_flags       <= '{de: scan_vis, hs: h_sync, vs: v_sync};
      if (scan_vis) begin
        bus.req_x <= h_cnt;
        bus.req_y <= v_cnt;
      end
      bus.line_start  <= (h_cnt == '0);
      bus.frame_start <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign bus.req = req_flags.de;

  scan_flags_t pipe [DEPTH];
  scan_flags_t tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else begin
      pipe[0] <= req_flags;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign tail = pipe[DEPTH-1];

  logic [3*COLOR_W-1:0] pix;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_W = (H_VISIBLE >= 8) ? H_VISIBLE / 8 : 1;

  logic [COORD_W-1:0] x_pipe [DEPTH];
  logic [COORD_W-1:0] bar_idx;
  logic [2:0]         bar_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        x_pipe[i] <= '0;
      end
    end else begin
      x_pipe[0] <= bus.req_x;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        x_pipe[i] <= x_pipe[i-1];
      end
    end
  end

  assign bar_idx  = x_pipe[DEPTH-1] / COORD_W'(BAR_W);
  assign bar_mask = bar_rgb(bar_e'(bar_idx[2:0]));

  always_comb begin
    pix = '0;
    if (tail.de) begin
      if (test_mode) begin
        pix = {{COLOR_W{bar_mask[2]}}, {COLOR_W{bar_mask[1]}}, {COLOR_W{bar_mask[0]}}};
      end else begin
        pix = bus.color_in;
      end
    end
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  always_comb begin
    pix = '0;
    if (tail.de) begin
      pix = bus.color_in;
    end
  end
`endif

  // Output stage: colour sampled here is the one returned for the request PRE_ACTIVE cycles back.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.de    <= 1'b0;
      bus.hsync <= ~HS_ON;
      bus.vsync <= ~VS_ON;
      bus.red   <= '0;
      bus.green <= '0;
      bus.blue  <= '0;
    end else begin
      bus.de    <= tail.de;
      bus.hsync <= tail.hs ? HS_ON : ~HS_ON;
      bus.vsync <= tail.vs ? VS_ON : ~VS_ON;
      {bus.red, bus.green, bus.blue} <= pix;
    end
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen with an 8/2/3/3 x 4/1/2/1 raster and two-cycle colour source.
module tb_vga_scan_gen;

  logic clk;
  logic rst;
  logic test_mode;
  logic chk_en;

  int n_tests = 0;
  int n_fail  = 0;
  int pos     = 0;

  logic [23:0] sb [$];
  int hs_low_cnt, vs_low_cnt, req_cnt;

  localparam logic [23:0] BARS [8] = '{
    24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
    24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF
  };

  vga_scan_gen_if #(.COORD_W(11), .COLOR_W(8)) vif ();
  vga_scan_gen_if #(.COORD_W(11), .COLOR_W(8)) pif ();

  vga_scan_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(0), .VS_POL(0), .PRE_ACTIVE(2), .COORD_W(11), .COLOR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .test_mode(test_mode), .bus(vif)
  );

  vga_scan_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HS_POL(1), .VS_POL(1), .PRE_ACTIVE(2), .COORD_W(11), .COLOR_W(8)
  ) dut_pos (
    .clk(clk), .rst(rst), .test_mode(test_mode), .bus(pif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit vis(input int q);
    return ((q % 16) < 8) && (((q / 16) % 8) < 4);
  endfunction

  function automatic bit hs_act(input int q);
    return ((q % 16) >= 10) && ((q % 16) <= 12);
  endfunction

  function automatic bit vs_act(input int q);
    return (((q / 16) % 8) == 5) || (((q / 16) % 8) == 6);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (pos %0d)", name, act, exp, pos);
    end
  endtask

  // Scan position model: pos counts edges since reset release, output position is pos-1.
  always @(posedge clk) begin
    if (rst) begin
      pos = 0;
      sb.delete();
    end else begin
      pos++;
    end
  end

  // Colour source: answers each modelled request two cycles later and queues the expected pixel.
  initial begin
    vif.color_in = 24'hC3C3C3;
    pif.color_in = 24'h000000;
    forever begin
      @(posedge clk);
      #1;
      if (pos >= 3 && vis(pos - 3)) begin
        int r;
        logic [23:0] c;
        r = pos - 3;
        c = {8'(r % 16), 8'((r / 16) % 8), 8'h5A};
        vif.color_in = c;
`ifdef VGA_TEST_PATTERN_EN
        sb.push_back(test_mode ? BARS[r % 16] : c);
`else
        sb.push_back(c);
`endif
      end else begin
        vif.color_in = 24'hC3C3C3;
      end
    end
  end

  // Monitor: per-cycle checks against the position model, rgb checked via scoreboard pop on de.
  always @(negedge clk) begin
    if (chk_en) begin
      if (pos == 0) begin
        chk("rst_req", vif.req, 0);
        chk("rst_de", vif.de, 0);
        chk("rst_line_start", vif.line_start, 0);
        chk("rst_frame_start", vif.frame_start, 0);
        chk("rst_req_x", vif.req_x, 0);
        chk("rst_req_y", vif.req_y, 0);
        chk("rst_rgb", {vif.red, vif.green, vif.blue}, 0);
        chk("rst_hsync", vif.hsync, 1);
        chk("rst_vsync", vif.vsync, 1);
        chk("rst_hsync_pos", pif.hsync, 0);
        chk("rst_vsync_pos", pif.vsync, 0);
      end else begin
        int p, h, v, d;
        bit e_de, e_hs, e_vs;
        p = pos - 1;
        h = p % 16;
        v = (p / 16) % 8;
        chk("req", vif.req, vis(p));
        if (vis(p)) begin
          chk("req_x", vif.req_x, h);
          chk("req_y", vif.req_y, v);
        end else begin
          chk("req_x_hold", vif.req_x, 7);
          chk("req_y_hold", vif.req_y, (v < 4) ? v : 3);
        end
        chk("line_start", vif.line_start, h == 0);
        chk("frame_start", vif.frame_start, (p % 128) == 0);
        d = p - 3;
        e_de = (d >= 0) && vis(d);
        e_hs = (d >= 0) && hs_act(d);
        e_vs = (d >= 0) && vs_act(d);
        chk("de", vif.de, e_de);
        chk("hsync", vif.hsync, !e_hs);
        chk("vsync", vif.vsync, !e_vs);
        chk("hsync_pos", pif.hsync, e_hs);
        chk("vsync_pos", pif.vsync, e_vs);
        if (vif.de) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: got de=1 expected a queued pixel (pos %0d)", pos);
          end else begin
            chk("rgb", {vif.red, vif.green, vif.blue}, sb.pop_front());
          end
        end else begin
          chk("blank_rgb", {vif.red, vif.green, vif.blue}, 0);
        end
        if (p == 128) begin
          hs_low_cnt = 0;
          vs_low_cnt = 0;
          req_cnt    = 0;
        end
        if (p >= 128 && p <= 255) begin
          hs_low_cnt += (vif.hsync == 1'b0) ? 1 : 0;
          vs_low_cnt += (vif.vsync == 1'b0) ? 1 : 0;
          req_cnt    += (vif.req == 1'b1) ? 1 : 0;
        end
        if (p == 255) begin
          chk("hsync_low_per_frame", hs_low_cnt, 24);
          chk("vsync_low_per_frame", vs_low_cnt, 32);
          chk("req_per_frame", req_cnt, 32);
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    test_mode = 1'b0;
    chk_en    = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    // Two full frames and a bit, then a plain reset.
    repeat (300) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    // Stop at output position 37 (h 5, v 2) and reset for one cycle; bars from here on.
    repeat (38) @(posedge clk);
    #1 begin
      rst       = 1'b1;
      test_mode = 1'b1;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (200) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_scan_gen.md
VGA_SCAN_GEN -- requirements
Module: vga_scan_gen

Interface
REQ-001 Parameters SHALL be: H_VISIBLE 1024, horizontal visible pixels; H_FRONT 24, front porch; H_SYNC 136, sync width; H_BACK 160, back porch; V_VISIBLE 768, V_FRONT 3, V_SYNC 6, V_BACK 29, vertical equivalents in lines.
REQ-002 Parameters SHALL also be: HS_POL 0, hsync active level; VS_POL 0, vsync active level; PRE_ACTIVE 1, colour source latency in cycles (range 1..8); COORD_W 11, coordinate width; COLOR_W 8, bits per channel.
REQ-003 Ports: clk  in  1  pixel clock, sole clock.
REQ-004 Ports: rst  in  1  synchronous, active-high reset.
REQ-005 Ports: color_in  in  3*COLOR_W  {r,g,b} for the pixel requested PRE_ACTIVE cycles earlier.
REQ-006 Ports: test_mode  in  1  selects internal test pattern (see Configuration).
REQ-007 Ports: req, req_x, req_y  out  1/COORD_W/COORD_W  pixel fetch request and its coordinates.
REQ-008 Ports: hsync, vsync, de  out  1 each  sync outputs and display enable, aligned with rgb.
REQ-009 Ports: line_start, frame_start  out  1 each  single-cycle pulses, aligned with req.
REQ-010 Ports: red, green, blue  out  COLOR_W each  pixel colour.

Function
REQ-011 Line order SHALL be visible, front, sync, back; H_LINE = sum of H terms; V_FRAME = sum of V terms.
REQ-012 Horizontal counter SHALL run 0..H_LINE-1 every clk and wrap to 0; vertical counter SHALL advance only on the horizontal wrap cycle (clock enable, no derived clock) and wrap after V_FRAME-1.
REQ-013 req SHALL be 1 iff h_cnt < H_VISIBLE and v_cnt < V_VISIBLE; req_x/req_y SHALL equal h_cnt/v_cnt while req, and hold their last value otherwise.
REQ-014 line_start SHALL pulse when h_cnt == 0; frame_start SHALL pulse when h_cnt == 0 and v_cnt == 0.
REQ-015 rgb SHALL be registered from color_in exactly PRE_ACTIVE cycles after the matching req; total req-to-rgb latency SHALL be PRE_ACTIVE+1 cycles.
REQ-016 hsync, vsync and de SHALL be delayed by PRE_ACTIVE+1 cycles via shift register, so that they describe the same scan position as rgb.
REQ-017 hsync SHALL be HS_POL when the delayed h position is in the sync interval, else !HS_POL; vsync likewise with VS_POL.
REQ-018 rgb SHALL be 0 whenever de is 0.
REQ-019 A colour value arriving while its delayed req bit is 0 SHALL be ignored.

Reset
REQ-020 While rst is 1: counters 0; req, de, line_start, frame_start 0; req_x/req_y 0; rgb 0; hsync = !HS_POL; vsync = !VS_POL; all delay stages cleared.
REQ-021 In the first cycle after rst falls, req SHALL be 1 with (0,0) and frame_start SHALL be 1.
REQ-022 Reset asserted mid-frame SHALL take effect on the next clk edge, with no partial pulses afterwards.

Configuration
REQ-023 Macro VGA_TEST_PATTERN_EN: when defined and test_mode=1, rgb SHALL be 8 vertical colour bars of width H_VISIBLE/8, indexed by the delayed x; bar order black, blue, green, cyan, red, magenta, yellow, white, each channel all-ones or 0.
REQ-024 Without VGA_TEST_PATTERN_EN, test_mode SHALL be ignored and no bar logic SHALL be synthesised.

Structure
REQ-025 Package vga_pkg SHALL hold the timing constants for 640x480@60 and 1024x768@60, and the bar colour table.
REQ-026 Sub-module vga_axis_counter (parameters VISIBLE/FRONT/SYNC/BACK; inputs clk, rst, en; outputs cnt, wrap, visible, in_sync) SHALL be instantiated once for h (en=1) and once for v (en=h wrap).

Verification (H 8/2/3/3, V 4/1/2/1, PRE_ACTIVE 2)
REQ-027 Release rst -> req=1 at (0,0) and frame_start=1 in the same cycle; first de=1 exactly 3 cycles later.
REQ-028 Free run -> hsync low for 3 cycles every 16; vsync low for 2 lines every 8 lines (128 cycles); req high 32 cycles per frame.
REQ-029 Return color_in = {x,y,0x5A} 2 cycles after each req -> red/green/blue equal that value with de=1; colour driven during blanking -> rgb 0.
REQ-030 HS_POL=1, VS_POL=1 -> sync pulses inverted; reset level low.
REQ-031 Assert rst at h_cnt 5, v_cnt 2 for 1 cycle -> all outputs at reset values the next cycle; restart per REQ-021.
REQ-032 VGA_TEST_PATTERN_EN defined, test_mode=1 -> x=0 gives rgb 0/0/0, x=7 gives 0xFF/0xFF/0xFF, with bar width 1.
